serial_byte_rx: RTL

Bit-serial receiver feeding the 8-bit `count01` stage.
- Takes a qualified serial bit stream framed as start bit (0), WIDTH data bits MSB-first, and stop bit (1).
- Assembles each data word and presents it on a one-entry valid/ready output register.
- Flags framing errors and overruns with one-cycle pulses.

---
 rtl/serial_byte_rx_pkg.sv | 17 +
 rtl/serial_byte_rx_if.sv | 37 +++
 rtl/serial_byte_rx.sv | 75 +++++++
 3 files changed

// File: rtl/serial_byte_rx_pkg.sv
// Shared definitions for the serial byte receiver.
// State encoding and the default word width shared with count01.
package serial_byte_rx_pkg;

  localparam int WIDTH_DEF = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    DATA = S_DATA,
    STOP = S_STOP
  } state_t;

endpackage

// File: rtl/serial_byte_rx_if.sv
// Serial-in / word-out handshake bundle for serial_byte_rx.
// slave is the receiver side, master is the driver/consumer side.
interface serial_byte_rx_if
  import serial_byte_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] byte_out;
  logic             byte_valid;
  logic             byte_ready;
  logic             frame_err;
  logic             overrun;

  modport master (
    output bit_in,
    output bit_valid,
    output byte_ready,
    input  byte_out,
    input  byte_valid,
    input  frame_err,
    input  overrun
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  byte_ready,
    output byte_out,
    output byte_valid,
    output frame_err,
    output overrun
  );

endinterface

// File: rtl/serial_byte_rx.sv
// Bit-serial frame receiver: start, WIDTH data bits MSB-first, stop.
// Words land in a one-entry valid/ready register; errors pulse.
module serial_byte_rx
  import serial_byte_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic             clk,
  input logic             reset,
  serial_byte_rx_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] out_q;
  logic             vld_q;
  logic             ferr_q;
  logic             ovr_q;

  assign bus.byte_out   = out_q;
  assign bus.byte_valid = vld_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      shreg  <= '0;
      out_q  <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
      if (vld_q && bus.byte_ready)
        vld_q <= 1'b0;
      if (bus.bit_valid) begin
        unique case (state)
          IDLE: begin
            if (!bus.bit_in) begin
              state <= DATA;
              cnt   <= '0;
              shreg <= '0;
            end
          end
          DATA: begin
            shreg <= {shreg[WIDTH-2:0], bus.bit_in};
            cnt   <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1))
              state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!bus.bit_in) begin
              ferr_q <= 1'b1;
            end else if (!vld_q || bus.byte_ready) begin
              // a same-edge consume frees the slot for this word
              out_q <= shreg;
              vld_q <= 1'b1;
            end else begin
              ovr_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
